// File: rtl/rggen_lock_key_controller.sv
// Register-access lock controller: a two-key write sequence unlocks rwe/rwl fields.
// Optional relock timeout is compiled in with RGGEN_LOCK_KEY_TIMEOUT_EN.
module rggen_lock_key_controller #(
   parameter int unsigned           KEY_WIDTH = 8,
   parameter logic [KEY_WIDTH-1:0] KEY0      = KEY_WIDTH'(8'h5A),
   parameter logic [KEY_WIDTH-1:0] KEY1      = KEY_WIDTH'(8'hA5),
   parameter int unsigned           TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_key_valid,
   input  logic [KEY_WIDTH-1:0] i_key_data,
   input  logic                 i_lock_request,
   input  logic                 i_freeze,
   output logic                 o_enable,
   output logic                 o_lock,
   output logic [1:0]           o_state,
   output logic                 o_violation,
   output logic                 o_timeout
);

   typedef enum logic [1:0] {
      ST_LOCKED   = 2'd0,
      ST_ARMED    = 2'd1,
      ST_UNLOCKED = 2'd2,
      ST_FROZEN   = 2'd3
   } state_e;

   // Elaboration-time parameter sanity checks
   if (KEY_WIDTH < 1 || KEY_WIDTH > 32) begin : g_bad_key_width
      $error("KEY_WIDTH must be in 1..32");
   end
   if (KEY0 == KEY1) begin : g_bad_keys
      $error("KEY0 and KEY1 must differ");
   end
   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("TIMEOUT must be in 1..65535");
   end

   state_e state_q, state_d;
   logic   enable_q;
   logic   lock_q;
   logic   violation_q, violation_d;
   logic   timeout_q, timeout_d;
   logic   key0_hit_c;
   logic   key1_hit_c;
   logic   timeout_hit_c;

   // Valid gates the compare so X on idle data never propagates
   assign key0_hit_c = i_key_valid && (i_key_data == KEY0);
   assign key1_hit_c = i_key_valid && (i_key_data == KEY1);

`ifdef RGGEN_LOCK_KEY_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign timeout_hit_c = (cnt_q == CNT_W'(TIMEOUT - 1));

   // Counts only while dwelling in ARMED/UNLOCKED; any transition clears it
   always_comb begin
      cnt_d = '0;
      if ((state_q == ST_ARMED || state_q == ST_UNLOCKED) && (state_d == state_q)) begin
         if (cnt_q != CNT_W'(TIMEOUT))
            cnt_d = cnt_q + CNT_W'(1);
         else
            cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   assign timeout_hit_c = 1'b0;
`endif

   // Next-state and event pulses; priority freeze > lock request > key > timeout
   always_comb begin
      state_d     = state_q;
      violation_d = 1'b0;
      timeout_d   = 1'b0;
      if (i_freeze) begin
         state_d = ST_FROZEN;
      end else begin
         case (state_q)
            ST_LOCKED: begin
               if (!i_lock_request && i_key_valid) begin
                  if (key0_hit_c) state_d = ST_ARMED;
                  else            violation_d = 1'b1;
               end
            end
            ST_ARMED: begin
               if (i_lock_request) begin
                  state_d = ST_LOCKED;
               end else if (i_key_valid) begin
                  if (key1_hit_c) begin
                     state_d = ST_UNLOCKED;
                  end else begin
                     state_d     = ST_LOCKED;
                     violation_d = 1'b1;
                  end
               end else if (timeout_hit_c) begin
                  state_d   = ST_LOCKED;
                  timeout_d = 1'b1;
               end
            end
            ST_UNLOCKED: begin
               if (i_lock_request) begin
                  state_d = ST_LOCKED;
               end else if (i_key_valid) begin
                  state_d = key0_hit_c ? ST_ARMED : ST_LOCKED;
               end else if (timeout_hit_c) begin
                  state_d   = ST_LOCKED;
                  timeout_d = 1'b1;
               end
            end
            ST_FROZEN: begin
               violation_d = i_key_valid;
            end
            default: state_d = ST_LOCKED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_LOCKED;
         enable_q    <= 1'b0;
         lock_q      <= 1'b1;
         violation_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         enable_q    <= (state_d == ST_UNLOCKED);
         lock_q      <= (state_d != ST_UNLOCKED);
         violation_q <= violation_d;
         timeout_q   <= timeout_d;
      end
   end

   assign o_enable    = enable_q;
   assign o_lock      = lock_q;
   assign o_state     = state_q;
   assign o_violation = violation_q;
   assign o_timeout   = timeout_q;

endmodule

// File: doc/rggen_lock_key_controller.md
RGGEN_LOCK_KEY_CONTROLLER -- requirements
Module: rggen_lock_key_controller

Interface
REQ-001 Parameter KEY_WIDTH, default 8, SHALL set the width of the unlock key bus; legal range 1..32.
REQ-002 Parameter KEY0, default 8'h5A, SHALL be the first key of the unlock sequence.
REQ-003 Parameter KEY1, default 8'hA5, SHALL be the second key of the unlock sequence; KEY1 != KEY0 SHALL hold.
REQ-004 Parameter TIMEOUT, default 16, SHALL set the relock timeout in clock cycles; legal range 1..65535.
REQ-005 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 i_key_valid  input  1  SHALL qualify i_key_data for one cycle per key write.
REQ-008 i_key_data  input  KEY_WIDTH  SHALL carry the written key value.
REQ-009 i_lock_request  input  1  SHALL force relock when high.
REQ-010 i_freeze  input  1  SHALL lock permanently until reset when high.
REQ-011 o_enable  output  1  SHALL be high only in UNLOCKED; drives rwe-type fields.
REQ-012 o_lock  output  1  SHALL equal ~o_enable; drives rwl-type fields.
REQ-013 o_state  output  2  SHALL expose the state: LOCKED=0, ARMED=1, UNLOCKED=2, FROZEN=3.
REQ-014 o_violation  output  1  SHALL pulse one cycle on a rejected key write.
REQ-015 o_timeout  output  1  SHALL pulse one cycle on a timeout-driven relock.

Function
REQ-016 All outputs SHALL be registered; o_enable/o_lock/o_state SHALL reflect the new state the cycle after the triggering input.
REQ-017 Event priority per cycle SHALL be: i_freeze > i_lock_request > i_key_valid > timeout.
REQ-018 Any state, i_freeze=1 -> FROZEN; FROZEN SHALL be left only by reset.
REQ-019 ARMED or UNLOCKED, i_lock_request=1 -> LOCKED; no violation, no timeout pulse.
REQ-020 LOCKED, key valid and data==KEY0 -> ARMED; data!=KEY0 -> stay LOCKED, o_violation pulse.
REQ-021 ARMED, key valid and data==KEY1 -> UNLOCKED; any other data -> LOCKED, o_violation pulse.
REQ-022 UNLOCKED, any key valid -> LOCKED (key write relocks); data==KEY0 SHALL additionally go to ARMED instead; no violation in either case.
REQ-023 FROZEN, key valid -> o_violation pulse, state unchanged; i_lock_request ignored.
REQ-024 Timeout counter width SHALL be $clog2(TIMEOUT+1); cleared on every entry to ARMED or UNLOCKED, increments each cycle in those states, never wraps.
REQ-025 Counter == TIMEOUT-1 with no higher-priority event -> LOCKED with o_timeout pulse; UNLOCKED therefore lasts exactly TIMEOUT cycles.
REQ-026 Key compare SHALL use full KEY_WIDTH equality; X on i_key_data while i_key_valid=0 SHALL be ignored.

Reset
REQ-027 rst_n low SHALL asynchronously force: state LOCKED, counter 0, o_enable 0, o_lock 1, o_state 0, o_violation 0, o_timeout 0.
REQ-028 Reset mid-sequence (ARMED/UNLOCKED/FROZEN) SHALL discard progress; first valid key after release SHALL be compared against KEY0.
REQ-029 Reset release SHALL be synchronous to clk by the integrating system; no internal synchronizer.

Configuration
REQ-030 Macro RGGEN_LOCK_KEY_TIMEOUT_EN defined SHALL compile in the timeout counter and REQ-024/025 behaviour.
REQ-031 Macro undefined SHALL remove the counter; o_timeout SHALL tie to 0; ARMED/UNLOCKED persist until key/lock/freeze events; TIMEOUT parameter ignored.

Verification
REQ-032 Reset, write 8'h5A then 8'hA5 -> o_state 0->1->2, o_enable=1 and o_lock=0 one cycle after second key.
REQ-033 LOCKED, write 8'h33 -> o_violation one-cycle pulse, o_state stays 0; ARMED, write 8'h5A -> o_state 0, violation pulse.
REQ-034 With macro, TIMEOUT=4, unlock and idle -> o_enable high exactly 4 cycles, o_timeout pulse, o_state 0.
REQ-035 UNLOCKED, i_lock_request and i_freeze same cycle -> o_state 3; then 8'h5A,8'hA5 -> violation pulses, o_enable stays 0.
REQ-036 ARMED, assert rst_n low mid-cycle -> outputs at reset values immediately; without macro, unlock holds 1000 cycles, o_timeout never asserts.
